// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_prog_loader_pkg;

    // First byte of every program frame
    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    // Error codes reported on err
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_COUNT   = 3'd1;
    localparam logic [2:0] ERR_FRAME   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CSUM    = 3'd4;

    // Frame-level loader states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // Byte receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizes rx, confirms the start bit at its
// midpoint, samples LSB-first at mid-bit, and flags a low stop bit.
module uart_byte_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int BIT_CYC = 868
) (
    input  logic       clk_in,
    input  logic       RST,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);

    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       rx_byte_reg, rx_byte_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high
    always_ff @(posedge clk_in) begin
        if (RST) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // State and datapath registers; reset also clears any half-received byte
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_reg     <= RX_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            rx_byte_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            rx_byte_reg   <= rx_byte_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Bit timing: half a bit to mid-start, then one full bit per sample
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + 1'b1;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        rx_byte_next   = rx_byte_reg;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) state_next = RX_START;
            end
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A line that is high again at mid-start was only a glitch
                    state_next   = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    if (rx_sync_reg) begin
                        rx_valid_next = 1'b1;
                        rx_byte_next  = shift_reg;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_valid  = rx_valid_reg;
    assign rx_byte   = rx_byte_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a framed program image over UART and writes it word by word into
// the instruction store, holding the CPU in reset while loading.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_W     = 10,
    parameter int TIMEOUT_MS = 50
) (
    input  logic              clk_in,
    input  logic              RST,
    input  logic              uart_rx,
    input  logic              load_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic [2:0]        err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int BIT_CYC     = CLK_HZ / BAUD;
    localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

    logic        rx_valid, frame_err;
    logic [7:0]  rx_byte;
    logic [15:0] n_field;
    logic        in_frame;

    loader_state_t     state_reg, state_next;
    logic [7:0]        cnt_hi_reg, cnt_hi_next;
    logic [ADDR_W:0]   n_reg, n_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [31:0]       wr_data_reg, wr_data_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
    logic [7:0]        xor_reg, xor_next;
    logic              wr_en_reg, wr_en_next;
    logic              done_reg, done_next;
    logic [2:0]        err_reg, err_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;

    uart_byte_rx #(
        .BIT_CYC(BIT_CYC)
    ) u_rx (
        .clk_in   (clk_in),
        .RST      (RST),
        .rx       (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

    assign n_field  = {cnt_hi_reg, rx_byte};
    // Timeout and framing errors only matter once a sync byte has been seen
    assign in_frame = (state_reg == ST_CNT_HI) || (state_reg == ST_CNT_LO) ||
                      (state_reg == ST_DATA)   || (state_reg == ST_CSUM);

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            cnt_hi_reg   <= '0;
            n_reg        <= '0;
            byte_cnt_reg <= '0;
            wr_data_reg  <= '0;
            wr_addr_reg  <= '0;
            word_cnt_reg <= '0;
            xor_reg      <= '0;
            wr_en_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= ERR_NONE;
            tmo_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_hi_reg   <= cnt_hi_next;
            n_reg        <= n_next;
            byte_cnt_reg <= byte_cnt_next;
            wr_data_reg  <= wr_data_next;
            wr_addr_reg  <= wr_addr_next;
            word_cnt_reg <= word_cnt_next;
            xor_reg      <= xor_next;
            wr_en_reg    <= wr_en_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            tmo_reg      <= tmo_next;
        end
    end

    // Next-state logic: load_en drop wins, then line errors, then frame parsing
    always_comb begin
        state_next    = state_reg;
        cnt_hi_next   = cnt_hi_reg;
        n_next        = n_reg;
        byte_cnt_next = byte_cnt_reg;
        wr_data_next  = wr_data_reg;
        wr_addr_next  = wr_addr_reg;
        word_cnt_next = word_cnt_reg;
        xor_next      = xor_reg;
        wr_en_next    = 1'b0;
        done_next     = done_reg;
        err_next      = err_reg;
        // Gap counter restarts on every received byte
        tmo_next      = (in_frame && !rx_valid) ? tmo_reg + 1'b1 : '0;

        if (!load_en) begin
            // Partially written image stays in IS; only status is cleared
            state_next = ST_IDLE;
            done_next  = 1'b0;
            err_next   = ERR_NONE;
        end else if (in_frame && frame_err) begin
            state_next = ST_ERR;
            err_next   = ERR_FRAME;
        end else if (in_frame && tmo_reg == TMO_LAST) begin
            state_next = ST_ERR;
            err_next   = ERR_TIMEOUT;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_SYNC;
                ST_SYNC: begin
                    if (rx_valid && rx_byte == LOADER_SYNC) state_next = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if (rx_valid) begin
                        cnt_hi_next = rx_byte;
                        state_next  = ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (rx_valid) begin
                        if (n_field == 16'd0 || {1'b0, n_field} > MAX_WORDS) begin
                            state_next = ST_ERR;
                            err_next   = ERR_COUNT;
                        end else begin
                            n_next        = (ADDR_W + 1)'(n_field);
                            wr_addr_next  = '0;
                            word_cnt_next = '0;
                            xor_next      = '0;
                            byte_cnt_next = '0;
                            state_next    = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Address advances the cycle after each write strobe
                    if (wr_en_reg) begin
                        wr_addr_next = wr_addr_reg + 1'b1;
                        if (word_cnt_reg == n_reg) state_next = ST_CSUM;
                    end
                    if (rx_valid) begin
                        wr_data_next  = {wr_data_reg[23:0], rx_byte};
                        xor_next      = xor_reg ^ rx_byte;
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == 2'd3) begin
                            wr_en_next    = 1'b1;
                            word_cnt_next = word_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_byte == xor_reg) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_ERR;
                            err_next   = ERR_CSUM;
                        end
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign word_cnt = word_cnt_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    // IDLE is only ever occupied with load_en low or straight after reset
    assign cpu_hold = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed frames, a vector table and random
// frames, with writes checked against a frame-level reference model.
module tb_uart_prog_loader;

    localparam int CLK_HZ      = 100_000;
    localparam int BAUD        = 10_000;
    localparam int ADDR_W      = 10;
    localparam int TIMEOUT_MS  = 3;
    localparam int BIT_CYC     = CLK_HZ / BAUD;
    localparam int TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;

    logic              clk_in  = 1'b0;
    logic              RST     = 1'b1;
    logic              uart_rx = 1'b1;
    logic              load_en = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic [2:0]        err;
    logic [ADDR_W:0]   word_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_rec_t;

    typedef struct {
        string       name;
        int          lead;
        logic [15:0] n_field;
        logic [7:0]  flip;
        logic [2:0]  want_err;
        logic        want_done;
    } vec_t;

    wr_rec_t    got_wr[$];
    wr_rec_t    exp_wr[$];
    logic [7:0] tx_q[$];
    logic [2:0] exp_err;
    logic       exp_done;
    int         exp_wcnt = 0;
    int         rx_pulses = 0;
    logic       wr_en_prev = 1'b0;
    vec_t       vecs[6];

    always #5 clk_in = ~clk_in;

    uart_prog_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .ADDR_W(ADDR_W),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk_in  (clk_in),
        .RST     (RST),
        .uart_rx (uart_rx),
        .load_en (load_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err),
        .word_cnt(word_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Capture every IS write and check strobe width and word_cnt alignment
    always @(negedge clk_in) begin
        wr_rec_t rec;
        if (wr_en) begin
            rec.addr = wr_addr;
            rec.data = wr_data;
            got_wr.push_back(rec);
            check("wcnt_at_write", 64'(word_cnt), 64'(wr_addr) + 64'd1);
            check("wr_en_one_cycle", 64'(wr_en_prev), 64'd0);
        end
        if (dut.u_rx.rx_valid) rx_pulses <= rx_pulses + 1;
        wr_en_prev <= wr_en;
    end

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (BIT_CYC) @(negedge clk_in);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_queue();
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
        repeat (2 * BIT_CYC) @(negedge clk_in);
    endtask

    task automatic restart_load();
        load_en = 1'b0;
        repeat (3) @(negedge clk_in);
        load_en = 1'b1;
        repeat (3) @(negedge clk_in);
        got_wr.delete();
    endtask

    task automatic build_frame(input int lead, input logic [15:0] n_field, input logic [7:0] flip);
        logic [7:0] b;
        logic [7:0] x;
        tx_q.delete();
        for (int i = 0; i < lead; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            tx_q.push_back(b);
        end
        tx_q.push_back(8'hA5);
        tx_q.push_back(n_field[15:8]);
        tx_q.push_back(n_field[7:0]);
        if (n_field != 16'd0 && int'(n_field) <= (1 << ADDR_W)) begin
            x = 8'h00;
            for (int i = 0; i < 4 * int'(n_field); i++) begin
                b = 8'($urandom);
                x = x ^ b;
                tx_q.push_back(b);
            end
            tx_q.push_back(x ^ flip);
        end
    endtask

    // Reference: parse the byte stream by the frame rules and list the expected writes
    task automatic model_frame();
        int i;
        int n;
        logic [7:0] x;
        wr_rec_t rec;
        exp_wr.delete();
        exp_err  = 3'd0;
        exp_done = 1'b0;
        i = 0;
        while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
        n = int'({tx_q[i+1], tx_q[i+2]});
        i = i + 3;
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_err = 3'd1;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            rec.addr = ADDR_W'(k);
            rec.data = {tx_q[i], tx_q[i+1], tx_q[i+2], tx_q[i+3]};
            x = x ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
            exp_wr.push_back(rec);
            i = i + 4;
        end
        exp_wcnt = n;
        if (tx_q[i] == x) exp_done = 1'b1;
        else exp_err = 3'd4;
    endtask

    task automatic compare_frame(input string name, input logic [2:0] want_err, input logic want_done);
        check({name, "_err"}, 64'(err), 64'(want_err));
        check({name, "_done"}, 64'(done), 64'(want_done));
        check({name, "_hold"}, 64'(cpu_hold), 64'd1);
        check({name, "_nwrites"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++) begin
            check({name, "_addr"}, 64'(got_wr[k].addr), 64'(exp_wr[k].addr));
            check({name, "_data"}, 64'(got_wr[k].data), 64'(exp_wr[k].data));
        end
        if (want_err != 3'd1) check({name, "_wcnt"}, 64'(word_cnt), 64'(exp_wcnt));
        $display("[TB] frame %s: %0d bytes, %0d writes, err=%0d done=%0d word_cnt=%0d",
                 name, tx_q.size(), got_wr.size(), err, done, word_cnt);
    endtask

    task automatic load_fixed(input logic [7:0] csum_flip);
        logic [7:0] body[8];
        logic [7:0] x;
        wr_rec_t rec;
        body = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        x = 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h02);
        for (int i = 0; i < 8; i++) tx_q.push_back(body[i]);
        tx_q.push_back(x ^ csum_flip);
        exp_wr.delete();
        rec.addr = '0;
        rec.data = 32'h12345678;
        exp_wr.push_back(rec);
        rec.addr = ADDR_W'(1);
        rec.data = 32'hDEADBEEF;
        exp_wr.push_back(rec);
        exp_wcnt = 2;
    endtask

    initial begin
        vecs[0] = '{"count_zero", 0, 16'h0000, 8'h00, 3'd1, 1'b0};
        vecs[1] = '{"count_over", 0, 16'h0401, 8'h00, 3'd1, 1'b0};
        vecs[2] = '{"three_words", 1, 16'd3, 8'h00, 3'd0, 1'b1};
        vecs[3] = '{"csum_bad_msb", 0, 16'd5, 8'h80, 3'd4, 1'b0};
        vecs[4] = '{"one_word", 0, 16'd1, 8'h00, 3'd0, 1'b1};
        vecs[5] = '{"lead_junk", 3, 16'd2, 8'h00, 3'd0, 1'b1};

        // Reset state
        repeat (5) @(negedge clk_in);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        RST = 1'b0;
        repeat (3) @(negedge clk_in);

        // Known two-word image, then the same image with a corrupted checksum
        restart_load();
        load_fixed(8'h00);
        send_queue();
        compare_frame("fixed_good", 3'd0, 1'b1);
        restart_load();
        load_fixed(8'h01);
        send_queue();
        compare_frame("fixed_badcsum", 3'd4, 1'b0);

        // Leading 00 FF before the sync byte
        restart_load();
        build_frame(0, 16'd1, 8'h00);
        tx_q.push_front(8'hFF);
        tx_q.push_front(8'h00);
        model_frame();
        send_queue();
        compare_frame("lead_00ff", exp_err, exp_done);

        // Table of count/checksum cases
        for (int v = 0; v < 6; v++) begin
            restart_load();
            build_frame(vecs[v].lead, vecs[v].n_field, vecs[v].flip);
            model_frame();
            send_queue();
            compare_frame(vecs[v].name, vecs[v].want_err, vecs[v].want_done);
        end

        // Stall two bytes into a word past the timeout, then drop load_en
        restart_load();
        tx_q.delete();
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
        repeat (TIMEOUT_CYC + 2 * BIT_CYC) @(negedge clk_in);
        check("tmo_err", 64'(err), 64'd3);
        check("tmo_nwrites", 64'(got_wr.size()), 64'd0);
        check("tmo_hold", 64'(cpu_hold), 64'd1);
        $display("[TB] frame timeout: err=%0d writes=%0d", err, got_wr.size());
        load_en = 1'b0;
        @(negedge clk_in);
        check("drop_hold", 64'(cpu_hold), 64'd0);
        check("drop_err", 64'(err), 64'd0);

        // Stop bit forced low inside DATA
        restart_load();
        tx_q = '{8'hA5, 8'h00, 8'h01};
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
        send_byte(8'h3C, 1'b0);
        repeat (2 * BIT_CYC) @(negedge clk_in);
        check("frame_err", 64'(err), 64'd2);
        check("frame_nwrites", 64'(got_wr.size()), 64'd0);
        $display("[TB] frame framing: err=%0d", err);

        // Short low glitch in SYNC produces no byte; a real frame still loads
        restart_load();
        begin
            int p0;
            p0 = rx_pulses;
            uart_rx = 1'b0;
            repeat (3) @(negedge clk_in);
            uart_rx = 1'b1;
            repeat (3 * BIT_CYC) @(negedge clk_in);
            check("glitch_no_byte", 64'(rx_pulses), 64'(p0));
            check("glitch_err", 64'(err), 64'd0);
            $display("[TB] glitch: rx bytes before=%0d after=%0d", p0, rx_pulses);
        end
        build_frame(0, 16'd1, 8'h00);
        model_frame();
        send_queue();
        compare_frame("after_glitch", exp_err, exp_done);

        // Reset in the middle of DATA, partway through a byte
        restart_load();
        build_frame(0, 16'd2, 8'h00);
        for (int i = 0; i < 7; i++) send_byte(tx_q[i], 1'b1);
        uart_rx = 1'b0;
        repeat (3 * BIT_CYC) @(negedge clk_in);
        check("pre_rst_wcnt", 64'(word_cnt), 64'd1);
        RST = 1'b1;
        @(negedge clk_in);
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        check("midrst_wr_data", 64'(wr_data), 64'd0);
        check("midrst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_word_cnt", 64'(word_cnt), 64'd0);
        $display("[TB] reset mid-data: word_cnt=%0d cpu_hold=%0d", word_cnt, cpu_hold);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk_in);
        RST = 1'b0;
        restart_load();
        build_frame(0, 16'd2, 8'h00);
        model_frame();
        send_queue();
        compare_frame("after_reset", exp_err, exp_done);

        // Random frames against the model
        for (int r = 0; r < 4; r++) begin
            logic [7:0] flip;
            flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            restart_load();
            build_frame($urandom_range(0, 2), 16'($urandom_range(1, 5)), flip);
            model_frame();
            send_queue();
            compare_frame($sformatf("random%0d", r), exp_err, exp_done);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
